// File: rtl/spi_display_receiver_pkg.sv
// rtl/spi_display_receiver_pkg.sv - shared constants and types for the 7-segment SPI display link
//
// Holds the MAX7219-style register address map and frame size. The SPI
// transmitter and the receiver both import this package.
package spi_display_receiver_pkg;

    localparam int FRAME_BITS = 16;

    // The bit counter stops here so oversized frames stay distinguishable
    // from exact ones without the counter wrapping back to 16.
    localparam logic [4:0] COUNT_SAT = 5'd17;

    localparam logic [3:0] NOOP      = 4'h0;
    localparam logic [3:0] DIGIT0    = 4'h1;
    localparam logic [3:0] DIGIT1    = 4'h2;
    localparam logic [3:0] DIGIT2    = 4'h3;
    localparam logic [3:0] DIGIT3    = 4'h4;
    localparam logic [3:0] DIGIT4    = 4'h5;
    localparam logic [3:0] DIGIT5    = 4'h6;
    localparam logic [3:0] DIGIT6    = 4'h7;
    localparam logic [3:0] DIGIT7    = 4'h8;
    localparam logic [3:0] DECODE    = 4'h9;
    localparam logic [3:0] INTENSITY = 4'hA;
    localparam logic [3:0] SCANLIMIT = 4'hB;
    localparam logic [3:0] SHUTDOWN  = 4'hC;
    localparam logic [3:0] TEST      = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_SHIFT
    } rx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - synchronizer with registered level and edge strobes for one SPI line
//
// Ports:
//   clk   - system clock
//   res   - synchronous active-high reset
//   din   - asynchronous input pin
//   level - synchronized level (also the edge-detect history flop)
//   rise  - one-cycle strobe, synchronized 0->1
//   fall  - one-cycle strobe, synchronized 1->0
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // level and the strobes are registered off the same chain output, so a
    // data line sampled via level lines up exactly with a clock line's rise.
    always_ff @(posedge clk) begin
        if (res) begin
            chain <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            level <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~level;
            fall  <= ~chain[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_display_receiver.sv
// rtl/spi_display_receiver.sv - oversampling SPI receiver and MAX7219-style shadow register file
//
// Ports:
//   clk, res                  - system clock, synchronous active-high reset
//   spi_clk/spi_mosi/spi_cs   - raw SPI pins (mode 0, MSB first, CS active low)
//   frame_valid/frame_error   - one-cycle pulses on a 16-bit / wrongly sized frame
//   frame_addr/frame_data     - fields of the last valid frame
//   rd_addr/rd_data           - combinational digit register read (0 = register 0x1)
//   decode_mode, intensity, scan_limit, shutdown, display_test - control registers
module spi_display_receiver
    import spi_display_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       res,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    output logic       frame_valid,
    output logic       frame_error,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown,
    output logic       display_test
);

    logic sclk_rise, mosi_level, cs_level, cs_rise;
    logic sclk_level_unused, sclk_fall_unused;
    logic mosi_rise_unused, mosi_fall_unused, cs_fall_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .res(res), .din(spi_clk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .res(res), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .res(res), .din(spi_cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall_unused)
    );

    rx_state_t             state;
    logic [FRAME_BITS-1:0] shift_reg, shift_next;
    logic [4:0]            bit_count, count_next;
    logic [7:0]            digits [8];
    logic [3:0]            wr_addr;
    logic [7:0]            wr_data;

    // The shift is folded in ahead of frame evaluation so a last SCLK rise
    // landing in the same cycle as the CS rise still counts.
    always_comb begin
        shift_next = shift_reg;
        count_next = bit_count;
        if (state == ST_SHIFT && sclk_rise) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], mosi_level};
            if (bit_count != COUNT_SAT) begin
                count_next = bit_count + 5'd1;
            end
        end
    end

    assign wr_addr = shift_next[11:8];
    assign wr_data = shift_next[7:0];
    assign rd_data = digits[rd_addr];

    always_ff @(posedge clk) begin
        if (res) begin
            state        <= ST_WAIT_IDLE;
            shift_reg    <= '0;
            bit_count    <= '0;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown     <= 1'b1;
            display_test <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digits[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                // Wait out any frame that was in flight when reset hit.
                ST_WAIT_IDLE: begin
                    if (cs_level) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!cs_level) begin
                        shift_reg <= '0;
                        bit_count <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_next;
                    bit_count <= count_next;
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        if (count_next == 5'(FRAME_BITS)) begin
                            frame_valid <= 1'b1;
                            frame_addr  <= wr_addr;
                            frame_data  <= wr_data;
                            case (wr_addr)
                                DIGIT0, DIGIT1, DIGIT2, DIGIT3,
                                DIGIT4, DIGIT5, DIGIT6, DIGIT7:
                                    digits[3'(wr_addr - DIGIT0)] <= wr_data;
                                DECODE:    decode_mode  <= wr_data;
                                INTENSITY: intensity    <= wr_data[3:0];
                                SCANLIMIT: scan_limit   <= wr_data[2:0];
                                SHUTDOWN:  shutdown     <= ~wr_data[0];
                                TEST:      display_test <= wr_data[0];
                                default: ;
                            endcase
                        end else if (count_next != 5'd0) begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_receiver.sv
// tb/tb_spi_display_receiver.sv - directed self-checking bench for spi_display_receiver
module tb_spi_display_receiver;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs = 1'b1;
    logic       frame_valid, frame_error;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown, display_test;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int error_cnt = 0;

    spi_display_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .res(res),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
        .frame_valid(frame_valid), .frame_error(frame_error),
        .frame_addr(frame_addr), .frame_data(frame_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown(shutdown),
        .display_test(display_test)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) valid_cnt++;
        if (frame_error === 1'b1) error_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drops CS and clocks out the low n bits of value MSB first; CS stays low.
    task automatic send_bits(input logic [31:0] value, input int n);
        @(negedge clk);
        spi_cs = 1'b0;
        wait_clks(3);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = value[i];
            wait_clks(2);
            spi_clk = 1'b1;
            wait_clks(3);
            spi_clk = 1'b0;
            wait_clks(2);
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        spi_cs = 1'b1;
        wait_clks(8);
    endtask

    task automatic send_frame(input logic [15:0] value);
        send_bits({16'h0, value}, 16);
        end_frame();
    endtask

    task automatic test_reset();
        res = 1'b1;
        wait_clks(3);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", frame_valid); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0h exp=0", frame_error); end
        checks++; if (frame_addr !== 4'h0 || frame_data !== 8'h00) begin failures++; $display("FAIL reset_frame got=%0h/%0h exp=0/0", frame_addr, frame_data); end
        checks++; if (shutdown !== 1'b1) begin failures++; $display("FAIL reset_shutdown got=%0h exp=1", shutdown); end
        checks++; if (decode_mode !== 8'h00 || intensity !== 4'h0 || scan_limit !== 3'h0 || display_test !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got=%0h/%0h/%0h/%0h exp=0/0/0/0", decode_mode, intensity, scan_limit, display_test);
        end
        for (int d = 0; d < 8; d++) begin
            rd_addr = 3'(d);
            #1;
            checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_digit%0d got=%0h exp=0", d, rd_data); end
        end
        rd_addr = 3'd0;
        @(negedge clk);
        res = 1'b0;
        wait_clks(6);
    endtask

    task automatic test_single_frame();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        send_bits(32'h0105, 16);
        @(negedge clk);
        spi_cs = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL latency_early_e%0d got=%0h exp=0", k - 1, frame_valid); end
        end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL latency_e3_valid got=%0h exp=1", frame_valid); end
        checks++; if (frame_addr !== 4'h1 || frame_data !== 8'h05) begin failures++; $display("FAIL latency_e3_fields got=%0h/%0h exp=1/05", frame_addr, frame_data); end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL valid_width got=%0h exp=0", frame_valid); end
        wait_clks(6);
        checks++; if (valid_cnt - v0 !== 1 || error_cnt - e0 !== 0) begin failures++; $display("FAIL single_pulses got=%0d/%0d exp=1/0", valid_cnt - v0, error_cnt - e0); end
        rd_addr = 3'd0; #1;
        checks++; if (rd_data !== 8'h05) begin failures++; $display("FAIL single_digit0 got=%0h exp=05", rd_data); end
    endtask

    task automatic test_shutdown_intensity();
        send_frame(16'h0C01);
        checks++; if (shutdown !== 1'b0) begin failures++; $display("FAIL shutdown_clear got=%0h exp=0", shutdown); end
        send_frame(16'h0A0F);
        checks++; if (intensity !== 4'hF) begin failures++; $display("FAIL intensity got=%0h exp=f", intensity); end
        checks++; if (decode_mode !== 8'h00 || scan_limit !== 3'h0 || display_test !== 1'b0 || shutdown !== 1'b0) begin
            failures++; $display("FAIL other_ctrl got=%0h/%0h/%0h/%0h exp=0/0/0/0", decode_mode, scan_limit, display_test, shutdown);
        end
        for (int d = 1; d < 8; d++) begin
            rd_addr = 3'(d); #1;
            checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL other_digit%0d got=%0h exp=0", d, rd_data); end
        end
    endtask

    task automatic test_bad_count();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        send_bits(32'h105, 12);
        end_frame();
        checks++; if (error_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin failures++; $display("FAIL short_pulses got=%0d/%0d exp=0/1", valid_cnt - v0, error_cnt - e0); end
        checks++; if (frame_addr !== 4'hA || frame_data !== 8'h0F) begin failures++; $display("FAIL short_fields got=%0h/%0h exp=a/0f", frame_addr, frame_data); end
        rd_addr = 3'd0; #1;
        checks++; if (rd_data !== 8'h05) begin failures++; $display("FAIL short_digit0 got=%0h exp=05", rd_data); end
        send_bits(32'h00207, 17);
        end_frame();
        checks++; if (error_cnt - e0 !== 2 || valid_cnt - v0 !== 0) begin failures++; $display("FAIL long_pulses got=%0d/%0d exp=0/2", valid_cnt - v0, error_cnt - e0); end
        rd_addr = 3'd1; #1;
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL long_digit1 got=%0h exp=0", rd_data); end
        // CS pulse without any clocks: silently ignored
        @(negedge clk); spi_cs = 1'b0;
        wait_clks(6);
        end_frame();
        checks++; if (error_cnt - e0 !== 2 || valid_cnt - v0 !== 0) begin failures++; $display("FAIL empty_pulses got=%0d/%0d exp=0/2", valid_cnt - v0, error_cnt - e0); end
    endtask

    task automatic test_registers();
        int v0;
        v0 = valid_cnt;
        send_frame(16'h09AB);
        send_frame(16'h0B07);
        send_frame(16'h0F01);
        checks++; if (decode_mode !== 8'hAB || scan_limit !== 3'h7 || display_test !== 1'b1) begin
            failures++; $display("FAIL ctrl_regs got=%0h/%0h/%0h exp=ab/7/1", decode_mode, scan_limit, display_test);
        end
        send_frame(16'h0D55);
        checks++; if (frame_addr !== 4'hD || frame_data !== 8'h55 || decode_mode !== 8'hAB || intensity !== 4'hF) begin
            failures++; $display("FAIL nowrite_addr got=%0h/%0h/%0h/%0h exp=d/55/ab/f", frame_addr, frame_data, decode_mode, intensity);
        end
        send_frame(16'hF1FF);
        rd_addr = 3'd0; #1;
        checks++; if (rd_data !== 8'hFF || frame_addr !== 4'h1) begin failures++; $display("FAIL upper_ignored got=%0h/%0h exp=ff/1", rd_data, frame_addr); end
        checks++; if (valid_cnt - v0 !== 5) begin failures++; $display("FAIL reg_valid_count got=%0d exp=5", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        send_bits(32'h08, 8);
        @(negedge clk); res = 1'b1;
        @(negedge clk);
        checks++; if (shutdown !== 1'b1 || intensity !== 4'h0 || decode_mode !== 8'h00 || frame_addr !== 4'h0) begin
            failures++; $display("FAIL midreset_outputs got=%0h/%0h/%0h/%0h exp=1/0/0/0", shutdown, intensity, decode_mode, frame_addr);
        end
        res = 1'b0;
        v0 = valid_cnt; e0 = error_cnt;
        send_bits(32'h33, 8);
        end_frame();
        checks++; if (valid_cnt - v0 !== 0 || error_cnt - e0 !== 0) begin failures++; $display("FAIL midreset_pulses got=%0d/%0d exp=0/0", valid_cnt - v0, error_cnt - e0); end
        rd_addr = 3'd7; #1;
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midreset_digit7 got=%0h exp=0", rd_data); end
        send_frame(16'h0833);
        checks++; if (rd_data !== 8'h33 || valid_cnt - v0 !== 1) begin failures++; $display("FAIL after_reset_frame got=%0h/%0d exp=33/1", rd_data, valid_cnt - v0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_bits(32'h0201, 16);
        @(negedge clk); spi_cs = 1'b1;
        @(negedge clk);
        send_bits(32'h0302, 16);
        end_frame();
        checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
        rd_addr = 3'd1; #1;
        checks++; if (rd_data !== 8'h01) begin failures++; $display("FAIL b2b_digit1 got=%0h exp=01", rd_data); end
        rd_addr = 3'd2; #1;
        checks++; if (rd_data !== 8'h02) begin failures++; $display("FAIL b2b_digit2 got=%0h exp=02", rd_data); end
    endtask

    task automatic test_same_cycle();
        int v0;
        logic [15:0] word;
        v0 = valid_cnt;
        word = 16'h0466;
        send_bits({17'h0, word[15:1]}, 15);
        spi_mosi = word[0];
        wait_clks(2);
        spi_clk = 1'b1;
        spi_cs = 1'b1;
        wait_clks(3);
        spi_clk = 1'b0;
        wait_clks(8);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL same_cycle_valid got=%0d exp=1", valid_cnt - v0); end
        rd_addr = 3'd3; #1;
        checks++; if (rd_data !== 8'h66 || frame_addr !== 4'h4) begin failures++; $display("FAIL same_cycle_digit3 got=%0h/%0h exp=66/4", rd_data, frame_addr); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_shutdown_intensity();
        test_bad_count();
        test_registers();
        test_reset_mid_frame();
        test_back_to_back();
        test_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_display_receiver.md
# spi_display_receiver

SPI peripheral-side receiver for the stopwatch's 7-segment display link: it is the far end of the three-wire serial stream (MOSI, CS, CLK) that the stopwatch's SPI transmitter emits. The block oversamples the bus in the system clock domain and reassembles 16-bit MAX7219-style frames. It decodes each frame into a shadow copy of the display driver's register file. The block serves as the on-chip loopback checker and as the display model in system-level simulation.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per SPI input line. Legal values are 2 or 3.
- `clk` input 1: system clock (100 MHz).
- `res` input 1: synchronous, active-high reset.
- `spi_clk` input 1: SPI serial clock. Idle low; data is sampled on its rising edge.
- `spi_mosi` input 1: serial data, MSB first.
- `spi_cs` input 1: chip select, active low.
- `frame_valid` output 1: one-cycle pulse when a correctly sized frame is accepted.
- `frame_error` output 1: one-cycle pulse when a frame has the wrong bit count.
- `frame_addr` output 4: address field (bits 11:8) of the last valid frame.
- `frame_data` output 8: data field (bits 7:0) of the last valid frame.
- `rd_addr` input 3: digit index to read (0 = digit register 0x1).
- `rd_data` output 8: combinational read of the selected digit register.
- `decode_mode` output 8: contents of register 0x9.
- `intensity` output 4: contents of register 0xA, bits 3:0.
- `scan_limit` output 3: contents of register 0xB, bits 2:0.
- `shutdown` output 1: shutdown is active. It holds the inverse of register 0xC bit 0.
- `display_test` output 1: contents of register 0xF, bit 0.

## Operation
- **Input conditioning.**
  - `spi_clk`, `spi_mosi` and `spi_cs` each pass through `SYNC_STAGES` flops, plus one history flop for edge detection.
  - An SCLK rise is the synchronized value going 0→1. A CS rise is the synchronized value going 0→1.
- **FSM states.**
  - WAIT_IDLE: the state after reset. It stays here until synchronized CS = 1, then moves to IDLE. This means a frame interrupted by reset is discarded whole.
  - IDLE: on synchronized CS = 0, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each SCLK rise, shift MOSI in at the LSB and increment the bit counter. The counter is 5 bits and saturates at 17. On a CS rise, evaluate the frame and go to IDLE.
- **Frame evaluation on a CS rise.**
  - Count = 16: pulse `frame_valid`, load `frame_addr`/`frame_data`, and perform the register write.
  - Count 1–15 or ≥17: pulse `frame_error`. No register write; `frame_addr`/`frame_data` are unchanged.
  - Count = 0: no pulse and no write.
- **Register write decode.** Bits 15:12 are ignored.
  - 0x0 (no-op): no write.
  - 0x1–0x8: digit[addr−1] ← data.
  - 0x9: decode_mode ← data.
  - 0xA: intensity ← data[3:0].
  - 0xB: scan_limit ← data[2:0].
  - 0xC: shutdown ← ~data[0].
  - 0xF: display_test ← data[0].
  - 0xD and 0xE: no write.
  - `frame_valid` pulses for every 16-bit frame, including addresses that produce no write.
- **Reset values.**
  - Digits, decode_mode, intensity, scan_limit, display_test, frame_addr, frame_data: all 0.
  - frame_valid and frame_error: 0.
  - shutdown: 1.
  - FSM: WAIT_IDLE.

## Timing
- Bus constraints:
  - SCLK high and low phases each ≥ 2 clk periods.
  - MOSI stable from 1 clk before to 1 clk after the SCLK rise.
  - CS high pulse ≥ 2 clk periods.
  - First SCLK rise ≥ 2 clk periods after the CS fall.
- Latency, with SYNC_STAGES = 2: let E be the clk edge that first samples a raw pin change.
  - The shift occurs on edge E+3.
  - `frame_valid`/`frame_error` assert on edge E+3 after the raw CS rise.
  - Register outputs update on the same edge.
  - Each extra sync stage adds 1 cycle.
- A CS rise and a last SCLK rise detected in the same cycle: the bit is shifted and counted before evaluation.
- Simultaneous read and write of the same digit: `rd_data` shows the old value in that cycle and the new value from the next cycle.
- `res` asserted mid-frame: all outputs return to reset values on the next edge, and the FSM enters WAIT_IDLE.

## Structure
- Shared package holds:
  - the register address constants (NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST);
  - FRAME_BITS = 16.
- The existing SPI transmitter imports the same package.
- Sub-module `spi_input_sync`: one instance per line, parameterized by SYNC_STAGES. It outputs the synchronized level plus rise/fall strobes.
- The FSM, shift register and register file live in the top of this block.

## Test plan
- After reset, send frame 0x0105 → `frame_valid` pulses once; frame_addr = 0x1, frame_data = 0x05; rd_addr = 0 gives rd_data = 0x05.
- Send 0x0C01, then 0x0A0F → shutdown goes 1→0; intensity = 0xF. Other registers stay at 0.
- Send a 12-bit frame 0x105 with CS raised early → `frame_error` pulses; no `frame_valid`; digit registers unchanged. Repeat with 17 bits → `frame_error`.
- Assert `res` after 8 bits of 0x0833 while CS is still low, then clock out the remaining 8 bits and raise CS → no pulse and no write. The next full frame 0x0833 writes digit 7 = 0x33.
- Send frames 0x0201 and 0x0302 back-to-back with a 2-clk CS-high gap → two `frame_valid` pulses; digit1 = 0x01, digit2 = 0x02.
- Loopback with the stopwatch SPI transmitter: every transmitted digit frame is matched by `frame_valid`, and the digit registers equal the counter values.
